// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch command path: commands, stopwatch
// FSM states and the command arbiter's own controller states.
package stopwatch_pkg;

  localparam int GUARD_CNT_W = 4;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_START = 2'b01,
    CMD_STOP  = 2'b10,
    CMD_RESET = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    SW_IDLE    = 2'b00,
    SW_RUNNING = 2'b01,
    SW_PAUSED  = 2'b10,
    SW_INVALID = 2'b11
  } sw_state_t;

  typedef enum logic {
    ARB_READY = 1'b0,
    ARB_GUARD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/stopwatch_cmd_legal.sv
// Combinational check of whether a command may be issued in the given
// stopwatch state; an invalid stopwatch state only accepts RESET.
module stopwatch_cmd_legal
  import stopwatch_pkg::*;
(
  input  logic [1:0] cmd,
  input  logic [1:0] fsm_state,
  output logic       legal
);

  always_comb begin
    legal = 1'b0;
    case (cmd)
      CMD_START: legal = (fsm_state == SW_IDLE) || (fsm_state == SW_PAUSED);
      CMD_STOP:  legal = (fsm_state == SW_RUNNING);
      CMD_RESET: legal = 1'b1;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/stopwatch_cmd_arbiter.sv
// Arbitrates panel and host command requests onto the stopwatch FSM,
// rejecting illegal commands and enforcing a guard gap after each issue.
module stopwatch_cmd_arbiter
  import stopwatch_pkg::*;
#(
  parameter int GUARD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       panel_req,
  input  logic [1:0] panel_cmd,
  input  logic       host_req,
  input  logic [1:0] host_cmd,
  input  logic [1:0] fsm_state,
  output logic       panel_ack,
  output logic       host_ack,
  output logic       cmd_err,
  output logic       start,
  output logic       stop,
  output logic       reset
);

  localparam logic [GUARD_CNT_W-1:0] GUARD_LOAD = GUARD_CNT_W'(GUARD_CYCLES - 1);

  arb_state_t             state, state_nxt;
  logic [GUARD_CNT_W-1:0] guard_cnt, guard_cnt_nxt;
  logic                   rr_host, rr_host_nxt;

  logic panel_ack_nxt, host_ack_nxt, cmd_err_nxt;
  logic start_nxt, stop_nxt, reset_nxt;

  logic       panel_pend, host_pend;
  logic       panel_rst, host_rst;
  logic       grant_host;
  logic [1:0] grant_cmd;
  logic       grant_legal;

  // A request is not seen again in the cycle its own ack is out, so a held
  // req cannot be issued twice; RESET beats anything else, ties go round-robin.
  always_comb begin
    panel_pend = panel_req && !panel_ack;
    host_pend  = host_req && !host_ack;
    panel_rst  = panel_pend && (panel_cmd == CMD_RESET);
    host_rst   = host_pend && (host_cmd == CMD_RESET);
    grant_host = 1'b0;
    if (panel_pend && host_pend) begin
      if (panel_rst != host_rst) grant_host = host_rst;
      else                       grant_host = rr_host;
    end else begin
      grant_host = host_pend;
    end
    grant_cmd = grant_host ? host_cmd : panel_cmd;
  end

  stopwatch_cmd_legal u_legal (
    .cmd       (grant_cmd),
    .fsm_state (fsm_state),
    .legal     (grant_legal)
  );

  always_comb begin
    state_nxt     = state;
    guard_cnt_nxt = guard_cnt;
    rr_host_nxt   = rr_host;
    panel_ack_nxt = 1'b0;
    host_ack_nxt  = 1'b0;
    cmd_err_nxt   = 1'b0;
    start_nxt     = 1'b0;
    stop_nxt      = 1'b0;
    reset_nxt     = 1'b0;
    case (state)
      ARB_READY: begin
        if (panel_pend || host_pend) begin
          panel_ack_nxt = !grant_host;
          host_ack_nxt  = grant_host;
          rr_host_nxt   = !grant_host;
          if (grant_legal) begin
            start_nxt     = (grant_cmd == CMD_START);
            stop_nxt      = (grant_cmd == CMD_STOP);
            reset_nxt     = (grant_cmd == CMD_RESET);
            state_nxt     = ARB_GUARD;
            guard_cnt_nxt = GUARD_LOAD;
          end else begin
            cmd_err_nxt = 1'b1;
          end
        end
      end
      ARB_GUARD: begin
        if (guard_cnt == '0) state_nxt = ARB_READY;
        else                 guard_cnt_nxt = guard_cnt - 1'b1;
      end
      default: state_nxt = ARB_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ARB_READY;
      guard_cnt <= '0;
      rr_host   <= 1'b0;
      panel_ack <= 1'b0;
      host_ack  <= 1'b0;
      cmd_err   <= 1'b0;
      start     <= 1'b0;
      stop      <= 1'b0;
      reset     <= 1'b0;
    end else begin
      state     <= state_nxt;
      guard_cnt <= guard_cnt_nxt;
      rr_host   <= rr_host_nxt;
      panel_ack <= panel_ack_nxt;
      host_ack  <= host_ack_nxt;
      cmd_err   <= cmd_err_nxt;
      start     <= start_nxt;
      stop      <= stop_nxt;
      reset     <= reset_nxt;
    end
  end

endmodule

// File: tb/tb_stopwatch_cmd_arbiter.sv
// Directed bench for stopwatch_cmd_arbiter; outputs are compared as the
// packed vector {panel_ack, host_ack, cmd_err, start, stop, reset}.
module tb_stopwatch_cmd_arbiter;
  import stopwatch_pkg::*;

  localparam logic [5:0] O_NONE    = 6'b000000;
  localparam logic [5:0] PA_START  = 6'b100100;
  localparam logic [5:0] PA_STOP   = 6'b100010;
  localparam logic [5:0] PA_RESET  = 6'b100001;
  localparam logic [5:0] PA_ERR    = 6'b101000;
  localparam logic [5:0] HA_START  = 6'b010100;
  localparam logic [5:0] HA_RESET  = 6'b010001;
  localparam logic [5:0] HA_ERR    = 6'b011000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       panel_req, host_req;
  logic [1:0] panel_cmd, host_cmd, fsm_state;
  logic       panel_ack, host_ack, cmd_err, start, stop, reset;
  logic [5:0] outs;

  int checks = 0;
  int passes = 0;

  assign outs = {panel_ack, host_ack, cmd_err, start, stop, reset};

  stopwatch_cmd_arbiter #(.GUARD_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .panel_req (panel_req),
    .panel_cmd (panel_cmd),
    .host_req  (host_req),
    .host_cmd  (host_cmd),
    .fsm_state (fsm_state),
    .panel_ack (panel_ack),
    .host_ack  (host_ack),
    .cmd_err   (cmd_err),
    .start     (start),
    .stop      (stop),
    .reset     (reset)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic p_req, input logic [1:0] p_cmd,
                               input logic h_req, input logic [1:0] h_cmd,
                               input logic [1:0] fsm);
    panel_req = p_req;
    panel_cmd = p_cmd;
    host_req  = h_req;
    host_cmd  = h_cmd;
    fsm_state = fsm;
  endtask

  task automatic checkOutput(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic stepAndCheck(input string tag, input logic [5:0] exp);
    @(posedge clk);
    #1;
    checkOutput(tag, outs, exp);
  endtask

  // Guard window after a legal issue: four quiet cycles before the next sample.
  task automatic guardQuiet(input string tag);
    repeat (4) stepAndCheck(tag, O_NONE);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, CMD_NOP, 1'b0, CMD_NOP, SW_IDLE);
    @(posedge clk);
    stepAndCheck("reset_state", O_NONE);
    rst_n = 1'b1;

    // Panel START, held request ignored during guard, served again after it.
    applyStimulus(1'b1, CMD_START, 1'b0, CMD_NOP, SW_IDLE);
    stepAndCheck("s1_first_start", PA_START);
    guardQuiet("s1_guard_ignores");
    stepAndCheck("s1_second_start", PA_START);
    applyStimulus(1'b0, CMD_NOP, 1'b0, CMD_NOP, SW_IDLE);
    guardQuiet("s1_guard_idle");

    // Illegal host STOP, then a host START that must wait out its own ack cycle.
    applyStimulus(1'b0, CMD_NOP, 1'b1, CMD_STOP, SW_IDLE);
    stepAndCheck("s2_stop_rejected", HA_ERR);
    applyStimulus(1'b0, CMD_NOP, 1'b1, CMD_START, SW_IDLE);
    stepAndCheck("s2_ignored_in_ack", O_NONE);
    stepAndCheck("s2_host_start", HA_START);
    applyStimulus(1'b0, CMD_NOP, 1'b0, CMD_NOP, SW_RUNNING);
    guardQuiet("s2_guard");

    // Host RESET beats panel STOP; panel STOP re-checked after the stopwatch went IDLE.
    applyStimulus(1'b1, CMD_STOP, 1'b1, CMD_RESET, SW_RUNNING);
    stepAndCheck("s3_reset_wins", HA_RESET);
    applyStimulus(1'b1, CMD_STOP, 1'b0, CMD_NOP, SW_IDLE);
    guardQuiet("s3_panel_pending");
    stepAndCheck("s3_stop_reevaluated", PA_ERR);
    applyStimulus(1'b0, CMD_NOP, 1'b0, CMD_NOP, SW_IDLE);

    // Continuous contention: host START / panel STOP alternate, five cycles apart.
    applyStimulus(1'b1, CMD_STOP, 1'b1, CMD_START, SW_IDLE);
    stepAndCheck("s4_grant1_host", HA_START);
    fsm_state = SW_RUNNING;
    guardQuiet("s4_gap1");
    stepAndCheck("s4_grant2_panel", PA_STOP);
    fsm_state = SW_PAUSED;
    guardQuiet("s4_gap2");
    stepAndCheck("s4_grant3_host", HA_START);
    fsm_state = SW_RUNNING;
    guardQuiet("s4_gap3");
    stepAndCheck("s4_grant4_panel", PA_STOP);
    applyStimulus(1'b0, CMD_NOP, 1'b0, CMD_NOP, SW_PAUSED);
    guardQuiet("s4_gap4");

    // Reset in the middle of guard with host START pending.
    applyStimulus(1'b1, CMD_RESET, 1'b0, CMD_NOP, SW_PAUSED);
    stepAndCheck("s5_panel_reset", PA_RESET);
    applyStimulus(1'b0, CMD_NOP, 1'b1, CMD_START, SW_PAUSED);
    stepAndCheck("s5_guard", O_NONE);
    rst_n = 1'b0;
    stepAndCheck("s5_in_reset", O_NONE);
    rst_n = 1'b1;
    stepAndCheck("s5_host_after_reset", HA_START);
    applyStimulus(1'b0, CMD_NOP, 1'b0, CMD_NOP, SW_INVALID);
    guardQuiet("s5_guard_after");

    // Invalid stopwatch state: only RESET passes.
    applyStimulus(1'b1, CMD_START, 1'b0, CMD_NOP, SW_INVALID);
    stepAndCheck("s6_start_rejected", PA_ERR);
    applyStimulus(1'b1, CMD_RESET, 1'b0, CMD_NOP, SW_INVALID);
    stepAndCheck("s6_ignored_in_ack", O_NONE);
    stepAndCheck("s6_reset_issued", PA_RESET);
    applyStimulus(1'b0, CMD_NOP, 1'b0, CMD_NOP, SW_IDLE);
    guardQuiet("s6_guard");

    // Both RESET: pointer favours host (panel served last), panel follows after guard.
    applyStimulus(1'b1, CMD_RESET, 1'b1, CMD_RESET, SW_RUNNING);
    stepAndCheck("s7_host_reset", HA_RESET);
    applyStimulus(1'b1, CMD_RESET, 1'b0, CMD_NOP, SW_IDLE);
    guardQuiet("s7_panel_pending");
    stepAndCheck("s7_panel_reset", PA_RESET);
    applyStimulus(1'b0, CMD_NOP, 1'b0, CMD_NOP, SW_IDLE);
    stepAndCheck("s7_quiet", O_NONE);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
